// File: rtl/tank_pkg.sv
// Shared types and constants for the per-player tank movement controller.
package tank_pkg;

    // Tank heading, matching the encoding seen by the sprite drawer.
    typedef enum logic [1:0] {
        DIR_LEFT  = 2'b00,
        DIR_RIGHT = 2'b01,
        DIR_DOWN  = 2'b10,
        DIR_UP    = 2'b11
    } dir_t;

    // Movement controller states.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        TURNING = 2'd1,
        MOVING  = 2'd2
    } motion_state_t;

    // Default key bindings (USB HID usage codes: A, D, S, W).
    localparam logic [7:0] KEYCODE_LEFT  = 8'h04;
    localparam logic [7:0] KEYCODE_RIGHT = 8'h07;
    localparam logic [7:0] KEYCODE_DOWN  = 8'h16;
    localparam logic [7:0] KEYCODE_UP    = 8'h1A;

    // Bit positions inside barrier_collision.
    localparam int unsigned BAR_RIGHT = 0;
    localparam int unsigned BAR_LEFT  = 1;
    localparam int unsigned BAR_DOWN  = 2;
    localparam int unsigned BAR_UP    = 3;

    // True when the barrier bit for heading d is set.
    function automatic logic is_blocked(input dir_t d, input logic [3:0] bar);
        case (d)
            DIR_RIGHT: return bar[BAR_RIGHT];
            DIR_LEFT:  return bar[BAR_LEFT];
            DIR_DOWN:  return bar[BAR_DOWN];
            default:   return bar[BAR_UP];
        endcase
    endfunction

endpackage

// File: rtl/tank_motion_if.sv
// Keyboard/control inputs and tank state outputs of one tank_motion instance.
interface tank_motion_if #(
    parameter int KEY_SLOTS = 6
);
    logic [8*KEY_SLOTS-1:0] keycodes;
    logic                   speed_upgrade;
    logic                   respawn;
    logic [3:0]             barrier_collision;
    logic [9:0]             tank_x;
    logic [9:0]             tank_y;
    logic [9:0]             tank_s;
    logic [1:0]             direction;
    logic                   moving;
    logic                   boost_active;

    // Driver side (game logic / keyboard bridge).
    modport master (
        output keycodes, speed_upgrade, respawn, barrier_collision,
        input  tank_x, tank_y, tank_s, direction, moving, boost_active
    );

    // Controller side.
    modport slave (
        input  keycodes, speed_upgrade, respawn, barrier_collision,
        output tank_x, tank_y, tank_s, direction, moving, boost_active
    );
endinterface

// File: rtl/tank_key_select.sv
// Priority decoder: lowest keyboard slot holding a bound key selects the command.
module tank_key_select
    import tank_pkg::*;
#(
    parameter int         KEY_SLOTS = 6,
    parameter logic [7:0] KEY_LEFT  = KEYCODE_LEFT,
    parameter logic [7:0] KEY_RIGHT = KEYCODE_RIGHT,
    parameter logic [7:0] KEY_DOWN  = KEYCODE_DOWN,
    parameter logic [7:0] KEY_UP    = KEYCODE_UP
) (
    input  logic [8*KEY_SLOTS-1:0] keycodes,
    output logic                   cmd_valid,
    output dir_t                   cmd_dir
);

    // Scan slots upward; once a match is found later slots are ignored.
    always_comb begin
        cmd_valid = 1'b0;
        cmd_dir   = DIR_RIGHT;
        for (int unsigned i = 0; i < KEY_SLOTS; i++) begin
            if (!cmd_valid) begin
                if (keycodes[8*i +: 8] == KEY_LEFT) begin
                    cmd_valid = 1'b1;
                    cmd_dir   = DIR_LEFT;
                end else if (keycodes[8*i +: 8] == KEY_RIGHT) begin
                    cmd_valid = 1'b1;
                    cmd_dir   = DIR_RIGHT;
                end else if (keycodes[8*i +: 8] == KEY_DOWN) begin
                    cmd_valid = 1'b1;
                    cmd_dir   = DIR_DOWN;
                end else if (keycodes[8*i +: 8] == KEY_UP) begin
                    cmd_valid = 1'b1;
                    cmd_dir   = DIR_UP;
                end
            end
        end
    end

endmodule

// File: rtl/tank_motion.sv
// Per-player tank movement controller, advanced once per video frame.
module tank_motion
    import tank_pkg::*;
#(
    parameter int         X_CENTER     = 160,
    parameter int         Y_CENTER     = 240,
    parameter int         X_MIN        = 1,
    parameter int         X_MAX        = 639,
    parameter int         Y_MIN        = 1,
    parameter int         Y_MAX        = 479,
    parameter int         TANK_SIZE    = 8,
    parameter int         BASE_STEP    = 1,
    parameter int         BOOST_STEP   = 3,
    parameter int         BOOST_FRAMES = 600,
    parameter int         TURN_FRAMES  = 1,
    parameter int         KEY_SLOTS    = 6,
    parameter logic [7:0] KEY_LEFT     = KEYCODE_LEFT,
    parameter logic [7:0] KEY_RIGHT    = KEYCODE_RIGHT,
    parameter logic [7:0] KEY_DOWN     = KEYCODE_DOWN,
    parameter logic [7:0] KEY_UP       = KEYCODE_UP
) (
    input logic          frame_clk,
    input logic          Reset,
    tank_motion_if.slave bus
);

    localparam logic [1:0] S_IDLE    = IDLE;
    localparam logic [1:0] S_TURNING = TURNING;
    localparam logic [1:0] S_MOVING  = MOVING;

    localparam logic [10:0] X_LO       = 11'(X_MIN + TANK_SIZE);
    localparam logic [10:0] X_HI       = 11'(X_MAX - TANK_SIZE);
    localparam logic [10:0] Y_LO       = 11'(Y_MIN + TANK_SIZE);
    localparam logic [10:0] Y_HI       = 11'(Y_MAX - TANK_SIZE);
    localparam logic [9:0]  X_SPAWN    = 10'(X_CENTER);
    localparam logic [9:0]  Y_SPAWN    = 10'(Y_CENTER);
    localparam logic [9:0]  BOOST_LOAD = 10'(BOOST_FRAMES);
    localparam logic [3:0]  TURN_LOAD  = 4'(TURN_FRAMES);

    logic [9:0]  r_x, r_y;
    dir_t        r_dir;
    logic [1:0]  r_state;
    logic [3:0]  r_turn;
    logic [9:0]  r_boost;
    logic        r_moving;

    logic        w_cmd_valid;
    dir_t        w_cmd_dir;
    logic [10:0] w_step;
    logic [10:0] w_x_plus, w_y_plus;
    logic        w_step_en;
    logic [9:0]  w_x_next, w_y_next, w_boost_next;
    dir_t        w_dir_next;
    logic [1:0]  w_state_next;
    logic [3:0]  w_turn_next;

    tank_key_select #(
        .KEY_SLOTS (KEY_SLOTS),
        .KEY_LEFT  (KEY_LEFT),
        .KEY_RIGHT (KEY_RIGHT),
        .KEY_DOWN  (KEY_DOWN),
        .KEY_UP    (KEY_UP)
    ) u_key_select (
        .keycodes  (bus.keycodes),
        .cmd_valid (w_cmd_valid),
        .cmd_dir   (w_cmd_dir)
    );

    // Step size depends on the boost counter before this edge.
    assign w_step   = (r_boost != '0) ? 11'(BOOST_STEP) : 11'(BASE_STEP);
    assign w_x_plus = {1'b0, r_x} + w_step;
    assign w_y_plus = {1'b0, r_y} + w_step;

    // Next-state logic: respawn overrides boost handling and the FSM.
    always_comb begin
        w_boost_next = r_boost;
        if (bus.speed_upgrade) begin
            w_boost_next = BOOST_LOAD;
        end else if (r_boost != '0) begin
            w_boost_next = r_boost - 10'd1;
        end

        w_state_next = r_state;
        w_dir_next   = r_dir;
        w_turn_next  = r_turn;
        w_step_en    = 1'b0;

        case (r_state)
            S_TURNING: begin
                if (!w_cmd_valid) begin
                    w_state_next = S_IDLE;
                end else if (w_cmd_dir != r_dir) begin
                    w_dir_next  = w_cmd_dir;
                    w_turn_next = TURN_LOAD;
                end else if (r_turn <= 4'd1) begin
                    w_turn_next  = '0;
                    w_state_next = S_MOVING;
                end else begin
                    w_turn_next = r_turn - 4'd1;
                end
            end
            default: begin
                // IDLE and MOVING react identically to a held command.
                if (!w_cmd_valid) begin
                    w_state_next = S_IDLE;
                end else if (w_cmd_dir == r_dir) begin
                    w_state_next = S_MOVING;
                    w_step_en    = 1'b1;
                end else begin
                    w_dir_next = w_cmd_dir;
                    if (TURN_LOAD == '0) begin
                        w_state_next = S_MOVING;
                        w_step_en    = 1'b1;
                    end else begin
                        w_turn_next  = TURN_LOAD;
                        w_state_next = S_TURNING;
                    end
                end
            end
        endcase

        w_x_next = r_x;
        w_y_next = r_y;
        if (w_step_en && !is_blocked(w_dir_next, bus.barrier_collision)) begin
            case (w_dir_next)
                DIR_LEFT:  w_x_next = ({1'b0, r_x} >= X_LO + w_step) ? 10'({1'b0, r_x} - w_step) : X_LO[9:0];
                DIR_RIGHT: w_x_next = (w_x_plus <= X_HI) ? w_x_plus[9:0] : X_HI[9:0];
                DIR_DOWN:  w_y_next = (w_y_plus <= Y_HI) ? w_y_plus[9:0] : Y_HI[9:0];
                default:   w_y_next = ({1'b0, r_y} >= Y_LO + w_step) ? 10'({1'b0, r_y} - w_step) : Y_LO[9:0];
            endcase
        end

        if (bus.respawn) begin
            w_x_next     = X_SPAWN;
            w_y_next     = Y_SPAWN;
            w_dir_next   = DIR_RIGHT;
            w_boost_next = '0;
            w_turn_next  = '0;
            w_state_next = S_IDLE;
        end
    end

    // Frame-rate state registers; moving flags an actual change of position.
    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            r_x      <= X_SPAWN;
            r_y      <= Y_SPAWN;
            r_dir    <= DIR_RIGHT;
            r_state  <= S_IDLE;
            r_turn   <= '0;
            r_boost  <= '0;
            r_moving <= 1'b0;
        end else begin
            r_x      <= w_x_next;
            r_y      <= w_y_next;
            r_dir    <= w_dir_next;
            r_state  <= w_state_next;
            r_turn   <= w_turn_next;
            r_boost  <= w_boost_next;
            r_moving <= (w_x_next != r_x) || (w_y_next != r_y);
        end
    end

    assign bus.tank_x       = r_x;
    assign bus.tank_y       = r_y;
    assign bus.tank_s       = 10'(TANK_SIZE);
    assign bus.direction    = r_dir;
    assign bus.moving       = r_moving;
    assign bus.boost_active = (r_boost != '0);

endmodule

// File: tb/tb_tank_motion.sv
// Directed testbench for tank_motion with default parameters.
module tb_tank_motion;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    tank_motion_if #(.KEY_SLOTS(6)) bus ();

    tank_motion #(.KEY_SLOTS(6)) u_dut (
        .frame_clk (clk),
        .Reset     (rst),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic frame();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.keycodes = '0;
        bus.speed_upgrade = 1'b0;
        bus.respawn = 1'b0;
        bus.barrier_collision = 4'b0000;
        #2;
        checks++; if (bus.tank_x !== 10'd160) begin errors++; $display("FAIL reset_x got %0d want 160", bus.tank_x); end
        checks++; if (bus.tank_y !== 10'd240) begin errors++; $display("FAIL reset_y got %0d want 240", bus.tank_y); end
        checks++; if (bus.tank_s !== 10'd8) begin errors++; $display("FAIL reset_s got %0d want 8", bus.tank_s); end
        checks++; if (bus.direction !== 2'b01) begin errors++; $display("FAIL reset_dir got %b want 01", bus.direction); end
        checks++; if (bus.moving !== 1'b0) begin errors++; $display("FAIL reset_moving got %b want 0", bus.moving); end
        checks++; if (bus.boost_active !== 1'b0) begin errors++; $display("FAIL reset_boost got %b want 0", bus.boost_active); end
        @(negedge clk);
        rst = 1'b0;
        frame();
        checks++; if (bus.tank_x !== 10'd160 || bus.moving !== 1'b0) begin errors++; $display("FAIL idle_hold got x=%0d mv=%b want x=160 mv=0", bus.tank_x, bus.moving); end
    endtask

    task automatic test_right_boost();
        bus.keycodes = {40'h0, 8'h07};
        for (int i = 1; i <= 5; i++) begin
            frame();
            checks++; if (bus.tank_x !== 10'(160 + i) || bus.moving !== 1'b1) begin errors++; $display("FAIL right_step%0d got x=%0d mv=%b want x=%0d mv=1", i, bus.tank_x, bus.moving, 160 + i); end
        end
        bus.speed_upgrade = 1'b1;
        frame();
        bus.speed_upgrade = 1'b0;
        checks++; if (bus.tank_x !== 10'd166) begin errors++; $display("FAIL pulse_step got x=%0d want 166", bus.tank_x); end
        checks++; if (bus.boost_active !== 1'b1) begin errors++; $display("FAIL boost_on got %b want 1", bus.boost_active); end
        frame();
        checks++; if (bus.tank_x !== 10'd169) begin errors++; $display("FAIL boost_step got x=%0d want 169", bus.tank_x); end
        bus.keycodes = '0;
        frame();
        checks++; if (bus.tank_x !== 10'd169 || bus.moving !== 1'b0) begin errors++; $display("FAIL release got x=%0d mv=%b want x=169 mv=0", bus.tank_x, bus.moving); end
        for (int i = 0; i < 597; i++) frame();
        checks++; if (bus.boost_active !== 1'b1) begin errors++; $display("FAIL boost_last got %b want 1", bus.boost_active); end
        frame();
        checks++; if (bus.boost_active !== 1'b0) begin errors++; $display("FAIL boost_expire got %b want 0", bus.boost_active); end
        bus.keycodes = {40'h0, 8'h07};
        frame();
        checks++; if (bus.tank_x !== 10'd170) begin errors++; $display("FAIL base_step_back got x=%0d want 170", bus.tank_x); end
    endtask

    task automatic test_reset_midmove();
        for (int i = 0; i < 30; i++) frame();
        checks++; if (bus.tank_x !== 10'd200) begin errors++; $display("FAIL reach_200 got x=%0d want 200", bus.tank_x); end
        bus.speed_upgrade = 1'b1;
        frame();
        bus.speed_upgrade = 1'b0;
        checks++; if (bus.tank_x !== 10'd201 || bus.boost_active !== 1'b1) begin errors++; $display("FAIL pre_reset got x=%0d b=%b want x=201 b=1", bus.tank_x, bus.boost_active); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (bus.tank_x !== 10'd160 || bus.tank_y !== 10'd240) begin errors++; $display("FAIL async_reset_pos got (%0d,%0d) want (160,240)", bus.tank_x, bus.tank_y); end
        checks++; if (bus.direction !== 2'b01 || bus.boost_active !== 1'b0 || bus.moving !== 1'b0) begin errors++; $display("FAIL async_reset_flags got d=%b b=%b m=%b want d=01 b=0 m=0", bus.direction, bus.boost_active, bus.moving); end
        bus.keycodes = '0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_turn();
        bus.keycodes = {40'h0, 8'h04};
        frame();
        checks++; if (bus.direction !== 2'b00 || bus.tank_x !== 10'd160 || bus.moving !== 1'b0) begin errors++; $display("FAIL turn_f1 got d=%b x=%0d m=%b want d=00 x=160 m=0", bus.direction, bus.tank_x, bus.moving); end
        frame();
        checks++; if (bus.direction !== 2'b00 || bus.tank_x !== 10'd160 || bus.moving !== 1'b0) begin errors++; $display("FAIL turn_f2 got d=%b x=%0d m=%b want d=00 x=160 m=0", bus.direction, bus.tank_x, bus.moving); end
        frame();
        checks++; if (bus.tank_x !== 10'd159 || bus.moving !== 1'b1) begin errors++; $display("FAIL turn_f3 got x=%0d m=%b want x=159 m=1", bus.tank_x, bus.moving); end
        frame();
        checks++; if (bus.tank_x !== 10'd158) begin errors++; $display("FAIL turn_f4 got x=%0d want 158", bus.tank_x); end
        bus.keycodes = '0;
        frame();
        checks++; if (bus.direction !== 2'b00 || bus.tank_x !== 10'd158) begin errors++; $display("FAIL turn_release got d=%b x=%0d want d=00 x=158", bus.direction, bus.tank_x); end
    endtask

    task automatic test_clamp();
        bus.keycodes = {40'h0, 8'h04};
        for (int i = 0; i < 147; i++) frame();
        checks++; if (bus.tank_x !== 10'd11) begin errors++; $display("FAIL clamp_approach got x=%0d want 11", bus.tank_x); end
        bus.speed_upgrade = 1'b1;
        frame();
        bus.speed_upgrade = 1'b0;
        checks++; if (bus.tank_x !== 10'd10) begin errors++; $display("FAIL clamp_x10 got x=%0d want 10", bus.tank_x); end
        frame();
        checks++; if (bus.tank_x !== 10'd9 || bus.moving !== 1'b1) begin errors++; $display("FAIL clamp_hit got x=%0d m=%b want x=9 m=1", bus.tank_x, bus.moving); end
        frame();
        checks++; if (bus.tank_x !== 10'd9 || bus.moving !== 1'b0) begin errors++; $display("FAIL clamp_hold got x=%0d m=%b want x=9 m=0", bus.tank_x, bus.moving); end
        bus.keycodes = '0;
        frame();
    endtask

    task automatic test_barrier();
        bus.respawn = 1'b1;
        frame();
        bus.respawn = 1'b0;
        checks++; if (bus.tank_x !== 10'd160 || bus.tank_y !== 10'd240 || bus.direction !== 2'b01) begin errors++; $display("FAIL respawn1 got (%0d,%0d) d=%b want (160,240) d=01", bus.tank_x, bus.tank_y, bus.direction); end
        checks++; if (bus.boost_active !== 1'b0) begin errors++; $display("FAIL respawn_boost got %b want 0", bus.boost_active); end
        bus.keycodes = {40'h0, 8'h1A};
        bus.barrier_collision = 4'b1000;
        for (int i = 0; i < 3; i++) frame();
        checks++; if (bus.tank_y !== 10'd240 || bus.direction !== 2'b11 || bus.moving !== 1'b0) begin errors++; $display("FAIL barrier_block got y=%0d d=%b m=%b want y=240 d=11 m=0", bus.tank_y, bus.direction, bus.moving); end
        bus.barrier_collision = 4'b0000;
        frame();
        checks++; if (bus.tank_y !== 10'd239 || bus.tank_x !== 10'd160 || bus.moving !== 1'b1) begin errors++; $display("FAIL barrier_clear got (%0d,%0d) m=%b want (160,239) m=1", bus.tank_x, bus.tank_y, bus.moving); end
    endtask

    task automatic test_priority_respawn();
        bus.keycodes = {24'h0, 8'h04, 8'h16, 8'h2C};
        frame();
        checks++; if (bus.direction !== 2'b10 || bus.tank_y !== 10'd239) begin errors++; $display("FAIL prio_dir got d=%b y=%0d want d=10 y=239", bus.direction, bus.tank_y); end
        frame();
        frame();
        checks++; if (bus.tank_y !== 10'd240 || bus.tank_x !== 10'd160) begin errors++; $display("FAIL prio_move1 got (%0d,%0d) want (160,240)", bus.tank_x, bus.tank_y); end
        frame();
        checks++; if (bus.tank_y !== 10'd241 || bus.moving !== 1'b1) begin errors++; $display("FAIL prio_move2 got y=%0d m=%b want y=241 m=1", bus.tank_y, bus.moving); end
        bus.respawn = 1'b1;
        frame();
        bus.respawn = 1'b0;
        checks++; if (bus.tank_x !== 10'd160 || bus.tank_y !== 10'd240 || bus.direction !== 2'b01) begin errors++; $display("FAIL respawn2 got (%0d,%0d) d=%b want (160,240) d=01", bus.tank_x, bus.tank_y, bus.direction); end
        frame();
        checks++; if (bus.direction !== 2'b10 || bus.tank_y !== 10'd240 || bus.moving !== 1'b0) begin errors++; $display("FAIL after_respawn got d=%b y=%0d m=%b want d=10 y=240 m=0", bus.direction, bus.tank_y, bus.moving); end
        bus.keycodes = '0;
        frame();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_right_boost();
        test_reset_midmove();
        test_turn();
        test_clamp();
        test_barrier();
        test_priority_respawn();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
